// File: rtl/bcd_hour_counter_cfg_if.sv
// Control/status bundle for bcd_hour_counter_cfg: preset, direction and display
// controls in; BCD count, display digits and status pulses out.
interface bcd_hour_counter_cfg_if;
  logic       EN;
  logic       UP;
  logic       LD;
  logic [3:0] LdH;
  logic [3:0] LdL;
  logic       ctrl;
  logic [3:0] CntH;
  logic [3:0] CntL;
  logic [3:0] DispH;
  logic [3:0] DispL;
  logic       PM;
  logic       CO;
  logic       ERR;

  modport master (
    output EN, UP, LD, LdH, LdL, ctrl,
    input  CntH, CntL, DispH, DispL, PM, CO, ERR
  );

  modport slave (
    input  EN, UP, LD, LdH, LdL, ctrl,
    output CntH, CntL, DispH, DispL, PM, CO, ERR
  );
endinterface

// File: rtl/bcd_hour_counter_cfg.sv
// Two-digit BCD modulo-MOD up/down counter with validated preset, registered
// wrap/error pulses and a combinational 12-hour display path.
module bcd_hour_counter_cfg #(
  parameter int unsigned MOD     = 24,
  parameter int unsigned RST_VAL = 0
) (
  input logic                   CP,
  input logic                   CR,
  bcd_hour_counter_cfg_if.slave bus
);

  localparam logic [7:0] MODV   = 8'(MOD);
  localparam logic [3:0] RST_H  = 4'(RST_VAL / 10);
  localparam logic [3:0] RST_L  = 4'(RST_VAL % 10);
  localparam logic [3:0] MAX_H  = 4'((MOD - 1) / 10);
  localparam logic [3:0] MAX_L  = 4'((MOD - 1) % 10);
  localparam logic       EVEN   = ((MOD % 2) == 0);
  localparam logic [7:0] HALFV  = 8'(MOD / 2);
  localparam logic [3:0] HALF_H = 4'((MOD / 2) / 10);
  localparam logic [3:0] HALF_L = 4'((MOD / 2) % 10);

  logic [3:0] cnt_h, cnt_l;
  logic       co, err;
  logic [7:0] v, ld_v;
  logic       state_bad, ld_ok, at_max, at_zero;
  logic [3:0] disp_h, disp_l;
  logic       pm;

  // Decimal magnitudes are used only for range compares; the count itself stays BCD.
  always_comb begin
    v         = 8'(cnt_h) * 8'd10 + 8'(cnt_l);
    ld_v      = 8'(bus.LdH) * 8'd10 + 8'(bus.LdL);
    state_bad = (cnt_h > 4'd9) || (cnt_l > 4'd9) || (v >= MODV);
    ld_ok     = (bus.LdH <= 4'd9) && (bus.LdL <= 4'd9) && (ld_v < MODV);
    at_max    = (cnt_h == MAX_H) && (cnt_l == MAX_L);
    at_zero   = (cnt_h == 4'd0) && (cnt_l == 4'd0);
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      cnt_h <= RST_H;
      cnt_l <= RST_L;
      co    <= 1'b0;
      err   <= 1'b0;
    end else begin
      co  <= 1'b0;
      err <= 1'b0;
      if (bus.LD) begin
        if (ld_ok) begin
          cnt_h <= bus.LdH;
          cnt_l <= bus.LdL;
        end else begin
          cnt_h <= '0;
          cnt_l <= '0;
          err   <= 1'b1;
        end
      end else if (state_bad) begin
        cnt_h <= '0;
        cnt_l <= '0;
        err   <= 1'b1;
      end else if (bus.EN) begin
        if (bus.UP) begin
          if (at_max) begin
            cnt_h <= '0;
            cnt_l <= '0;
            co    <= 1'b1;
          end else if (cnt_l == 4'd9) begin
            cnt_l <= '0;
            cnt_h <= cnt_h + 4'd1;
          end else begin
            cnt_l <= cnt_l + 4'd1;
          end
        end else begin
          if (at_zero) begin
            cnt_h <= MAX_H;
            cnt_l <= MAX_L;
            co    <= 1'b1;
          end else if (cnt_l == 4'd0) begin
            cnt_l <= 4'd9;
            cnt_h <= cnt_h - 4'd1;
          end else begin
            cnt_l <= cnt_l - 4'd1;
          end
        end
      end
    end
  end

  // 12-hour view: 0 shows H, values above H show v-H via digit-wise BCD subtract.
  always_comb begin
    disp_h = cnt_h;
    disp_l = cnt_l;
    if (EVEN && bus.ctrl) begin
      if (at_zero) begin
        disp_h = HALF_H;
        disp_l = HALF_L;
      end else if (v > HALFV) begin
        if (cnt_l < HALF_L) begin
          disp_l = cnt_l + 4'd10 - HALF_L;
          disp_h = cnt_h - HALF_H - 4'd1;
        end else begin
          disp_l = cnt_l - HALF_L;
          disp_h = cnt_h - HALF_H;
        end
      end
    end
    pm = EVEN ? (v >= HALFV) : 1'b0;
  end

  assign bus.CntH  = cnt_h;
  assign bus.CntL  = cnt_l;
  assign bus.DispH = disp_h;
  assign bus.DispL = disp_l;
  assign bus.PM    = pm;
  assign bus.CO    = co;
  assign bus.ERR   = err;

endmodule

// File: tb/tb_bcd_hour_counter_cfg.sv
// Directed bench for bcd_hour_counter_cfg across MOD=24/60/100/2 instances.
`timescale 1ns/100ps
module tb_bcd_hour_counter_cfg;

  logic        CP = 1'b0;
  logic        CR;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 CP = ~CP;

  bcd_hour_counter_cfg_if a ();
  bcd_hour_counter_cfg_if b ();
  bcd_hour_counter_cfg_if c ();
  bcd_hour_counter_cfg_if d ();
  bcd_hour_counter_cfg_if e ();

  bcd_hour_counter_cfg #(.MOD(24),  .RST_VAL(0))  u24  (.CP(CP), .CR(CR), .bus(a));
  bcd_hour_counter_cfg #(.MOD(24),  .RST_VAL(12)) u24r (.CP(CP), .CR(CR), .bus(b));
  bcd_hour_counter_cfg #(.MOD(60),  .RST_VAL(0))  u60  (.CP(CP), .CR(CR), .bus(c));
  bcd_hour_counter_cfg #(.MOD(100), .RST_VAL(0))  u100 (.CP(CP), .CR(CR), .bus(d));
  bcd_hour_counter_cfg #(.MOD(2),   .RST_VAL(0))  u2   (.CP(CP), .CR(CR), .bus(e));

  logic [7:0] ld_tab   [6] = '{8'h00, 8'h11, 8'h12, 8'h13, 8'h20, 8'h23};
  logic [7:0] disp_tab [6] = '{8'h12, 8'h11, 8'h12, 8'h01, 8'h08, 8'h11};
  logic [7:0] pm_tab   [6] = '{8'd0,  8'd0,  8'd1,  8'd1,  8'd1,  8'd1};

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  initial begin
    CR = 1'b1;
    a.EN = 1'b1; a.UP = 1'b1; a.LD = 1'b0; a.LdH = '0; a.LdL = '0; a.ctrl = 1'b0;
    b.EN = 1'b0; b.UP = 1'b0; b.LD = 1'b0; b.LdH = '0; b.LdL = '0; b.ctrl = 1'b0;
    c.EN = 1'b0; c.UP = 1'b0; c.LD = 1'b0; c.LdH = '0; c.LdL = '0; c.ctrl = 1'b0;
    d.EN = 1'b0; d.UP = 1'b0; d.LD = 1'b0; d.LdH = '0; d.LdL = '0; d.ctrl = 1'b0;
    e.EN = 1'b0; e.UP = 1'b0; e.LD = 1'b0; e.LdH = '0; e.LdL = '0; e.ctrl = 1'b0;

    #12;
    check("rst_cnt",  {a.CntH, a.CntL}, 8'h00);
    check("rst_co",   8'(a.CO), 8'd0);
    check("rst_err",  8'(a.ERR), 8'd0);
    check("rst_val12", {b.CntH, b.CntL}, 8'h12);
    CR = 1'b0;
    tick();
    check("release_first_edge", {a.CntH, a.CntL}, 8'h01);

    // up-count wrap on MOD=24
    a.EN = 1'b0; a.LD = 1'b1; a.LdH = 4'd2; a.LdL = 4'd2;
    tick();
    check("ld22", {a.CntH, a.CntL}, 8'h22);
    check("ld22_err", 8'(a.ERR), 8'd0);
    a.LD = 1'b0; a.EN = 1'b1; a.UP = 1'b1;
    tick();
    check("up23", {a.CntH, a.CntL}, 8'h23);
    check("up23_co", 8'(a.CO), 8'd0);
    tick();
    check("wrap00", {a.CntH, a.CntL}, 8'h00);
    check("wrap00_co", 8'(a.CO), 8'd1);
    tick();
    check("up01", {a.CntH, a.CntL}, 8'h01);
    check("up01_co", 8'(a.CO), 8'd0);

    // 12-hour display table
    a.EN = 1'b0; a.ctrl = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a.LD = 1'b1; a.LdH = ld_tab[i][7:4]; a.LdL = ld_tab[i][3:0];
      tick();
      check("disp_cnt", {a.CntH, a.CntL}, ld_tab[i]);
      check("disp12", {a.DispH, a.DispL}, disp_tab[i]);
      check("pm", 8'(a.PM), pm_tab[i]);
    end
    a.LD = 1'b0;
    a.ctrl = 1'b0;
    #1;
    check("disp24_immediate", {a.DispH, a.DispL}, 8'h23);
    check("pm_ctrl0", 8'(a.PM), 8'd1);
    check("cnt_unchanged", {a.CntH, a.CntL}, 8'h23);

    // down-count borrow and hold
    a.LD = 1'b1; a.LdH = 4'd0; a.LdL = 4'd1;
    tick();
    a.LD = 1'b0; a.EN = 1'b1; a.UP = 1'b0;
    tick();
    check("dn00", {a.CntH, a.CntL}, 8'h00);
    check("dn00_co", 8'(a.CO), 8'd0);
    tick();
    check("dn_wrap23", {a.CntH, a.CntL}, 8'h23);
    check("dn_wrap_co", 8'(a.CO), 8'd1);
    tick();
    check("dn22", {a.CntH, a.CntL}, 8'h22);
    check("dn22_co", 8'(a.CO), 8'd0);
    a.EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_cnt", {a.CntH, a.CntL}, 8'h22);
      check("hold_co", 8'(a.CO), 8'd0);
    end

    // load validation
    a.LD = 1'b1; a.EN = 1'b1; a.LdH = 4'd2; a.LdL = 4'd5;
    tick();
    check("ld25_cnt", {a.CntH, a.CntL}, 8'h00);
    check("ld25_err", 8'(a.ERR), 8'd1);
    a.EN = 1'b0; a.LdH = 4'd1; a.LdL = 4'd9;
    tick();
    check("ld19_cnt", {a.CntH, a.CntL}, 8'h19);
    check("ld19_err", 8'(a.ERR), 8'd0);
    a.LdH = 4'd1; a.LdL = 4'hA;
    tick();
    check("ld1A_cnt", {a.CntH, a.CntL}, 8'h00);
    check("ld1A_err", 8'(a.ERR), 8'd1);
    a.EN = 1'b1; a.UP = 1'b1; a.LdH = 4'd2; a.LdL = 4'd3;
    tick();
    check("ld23_over_en", {a.CntH, a.CntL}, 8'h23);
    check("ld23_co", 8'(a.CO), 8'd0);
    a.LD = 1'b0;
    tick();
    check("after_ld23_wrap", {a.CntH, a.CntL}, 8'h00);
    check("after_ld23_co", 8'(a.CO), 8'd1);

    // asynchronous reset mid-period
    a.EN = 1'b0; a.LD = 1'b1; a.LdH = 4'd1; a.LdL = 4'd7;
    b.LD = 1'b1; b.LdH = 4'd2; b.LdL = 4'd3;
    tick();
    a.LD = 1'b0;
    b.LD = 1'b0; b.EN = 1'b1; b.UP = 1'b1;
    tick();
    check("pre_rst_a17", {a.CntH, a.CntL}, 8'h17);
    check("pre_rst_b_co", 8'(b.CO), 8'd1);
    b.EN = 1'b0;
    #3;
    CR = 1'b1;
    #1;
    check("async_a", {a.CntH, a.CntL}, 8'h00);
    check("async_b", {b.CntH, b.CntL}, 8'h12);
    check("async_b_co", 8'(b.CO), 8'd0);
    CR = 1'b0;
    tick();
    check("post_rst_b", {b.CntH, b.CntL}, 8'h12);

    // Modulo-60 wrap and illegal-state recovery
    c.LD = 1'b1; c.LdH = 4'd5; c.LdL = 4'd8;
    tick();
    c.LD = 1'b0; c.EN = 1'b1; c.UP = 1'b1;
    tick();
    check("m60_59", {c.CntH, c.CntL}, 8'h59);
    check("m60_59_co", 8'(c.CO), 8'd0);
    tick();
    check("m60_00", {c.CntH, c.CntL}, 8'h00);
    check("m60_co", 8'(c.CO), 8'd1);
    c.EN = 1'b0;
    force u60.cnt_l = 4'hC;
    #1;
    release u60.cnt_l;
    tick();
    check("upset_cnt", {c.CntH, c.CntL}, 8'h00);
    check("upset_err", 8'(c.ERR), 8'd1);
    tick();
    check("upset_err_clear", 8'(c.ERR), 8'd0);

    // Modulo-100 boundaries and display
    d.ctrl = 1'b1; d.LD = 1'b1; d.LdH = 4'd9; d.LdL = 4'd9;
    tick();
    check("m100_99", {d.CntH, d.CntL}, 8'h99);
    check("m100_disp99", {d.DispH, d.DispL}, 8'h49);
    check("m100_pm99", 8'(d.PM), 8'd1);
    d.LD = 1'b0; d.EN = 1'b1; d.UP = 1'b1;
    tick();
    check("m100_wrap", {d.CntH, d.CntL}, 8'h00);
    check("m100_co", 8'(d.CO), 8'd1);
    check("m100_disp00", {d.DispH, d.DispL}, 8'h50);
    d.LD = 1'b1; d.EN = 1'b0; d.LdH = 4'd0; d.LdL = 4'd9;
    tick();
    d.LD = 1'b0; d.EN = 1'b1;
    tick();
    check("m100_carry10", {d.CntH, d.CntL}, 8'h10);
    check("m100_pm10", 8'(d.PM), 8'd0);

    // Modulo-2 sequence
    e.EN = 1'b1; e.UP = 1'b1; e.ctrl = 1'b1;
    tick();
    check("m2_1", {e.CntH, e.CntL}, 8'h01);
    check("m2_1_pm", 8'(e.PM), 8'd1);
    tick();
    check("m2_0", {e.CntH, e.CntL}, 8'h00);
    check("m2_0_co", 8'(e.CO), 8'd1);
    check("m2_0_disp", {e.DispH, e.DispL}, 8'h01);
    tick();
    check("m2_1b", {e.CntH, e.CntL}, 8'h01);
    check("m2_1b_co", 8'(e.CO), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
